// File: rtl/apb_arb_master.sv
// Two-requester round-robin arbiter in front of a single APB3 master port.
// Optional ACCESS-phase PREADY timeout is enabled with `define APB_ARB_TIMEOUT_EN.
module apb_arb_master #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_write,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_slverr,
    output logic [AW-1:0]   paddr,
    output logic            psel,
    output logic            penable,
    output logic            pwrite,
    output logic [DW-1:0]   pwdata,
    input  logic [DW-1:0]   prdata,
    input  logic            pready,
    input  logic            pslverr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]    state, state_d;
    logic          ptr, ptr_d;
    logic          owner, owner_d;
    logic          gnt_any, gnt_idx;
    logic          timeout;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d, rdata_d;
    logic          write_d, slverr_d, psel_d, penable_d;
    logic [1:0]    rsp_valid_d;

    // Pointed requester wins a tie; a lone requester always wins.
    always_comb begin
        gnt_any = |req_valid;
        gnt_idx = (req_valid == 2'b11) ? ptr : req_valid[1];
    end

    // Acceptance is same-cycle in IDLE; gated by rst_n so it stays low in reset.
    assign req_ready = (state == IDLE && gnt_any && rst_n) ? {gnt_idx, ~gnt_idx} : 2'b00;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt, to_cnt_d;

    assign timeout = (state == ACCESS) && !pready && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Counts stalled ACCESS cycles; cleared on every entry to SETUP.
    always_comb begin
        to_cnt_d = to_cnt;
        if (state_d == SETUP) begin
            to_cnt_d = '0;
        end else if (state == ACCESS && !pready) begin
            to_cnt_d = to_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
`endif

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        owner_d     = owner;
        addr_d      = paddr;
        write_d     = pwrite;
        wdata_d     = pwdata;
        rsp_valid_d = 2'b00;
        rdata_d     = rsp_rdata;
        slverr_d    = rsp_slverr;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    state_d = SETUP;
                    ptr_d   = ~gnt_idx;
                    owner_d = gnt_idx;
                    addr_d  = gnt_idx ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                    wdata_d = gnt_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                    write_d = req_write[gnt_idx];
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = {owner, ~owner};
                    rdata_d     = pwrite ? '0 : prdata;
                    slverr_d    = pslverr;
                end else if (timeout) begin
                    state_d     = IDLE;
                    rsp_valid_d = {owner, ~owner};
                    rdata_d     = '0;
                    slverr_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            owner      <= owner_d;
            paddr      <= addr_d;
            pwrite     <= write_d;
            pwdata     <= wdata_d;
            psel       <= psel_d;
            penable    <= penable_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rdata_d;
            rsp_slverr <= slverr_d;
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: phase checks inline, responses via a scoreboard queue.
module tb_apb_arb_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic            rsp_slverr, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]   paddr;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    apb_arb_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic owner, input logic [31:0] rdata, input logic slverr);
        exp_t e;
        e.owner  = owner;
        e.rdata  = rdata;
        e.slverr = slverr;
        return e;
    endfunction

    // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid !== 2'b00) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'({e.owner, ~e.owner}));
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b11; req_write = 2'b11;
        req_addr = '1; req_wdata = '1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_pwrite", 32'(pwrite), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_slverr", 32'(rsp_slverr), 32'h0);
        @(negedge clk);
        req_valid = 2'b00; rst_n = 1'b1;

        // Requester 0 write, zero-wait slave
        @(negedge clk);
        req_valid = 2'b01; req_write = 2'b01;
        req_addr = {32'h0, 32'h0000_A000}; req_wdata = {32'h0, 32'hDEAD_BEEF}; pready = 1'b1;
        #1 check("w_req_ready", 32'(req_ready), 32'h1);
        check("w_idle_psel", 32'(psel), 32'h0);
        q.push_back(mk(1'b0, 32'h0, 1'b0));
        @(negedge clk);
        req_valid = 2'b00;
        #1 check("w_setup_psel", 32'(psel), 32'h1);
        check("w_setup_penable", 32'(penable), 32'h0);
        check("w_setup_paddr", paddr, 32'h0000_A000);
        check("w_setup_pwrite", 32'(pwrite), 32'h1);
        check("w_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        @(negedge clk);
        #1 check("w_access_penable", 32'(penable), 32'h1);
        check("w_access_paddr", paddr, 32'h0000_A000);
        check("w_access_pwdata", pwdata, 32'hDEAD_BEEF);
        @(negedge clk);
        #1 check("w_rsp_pulse", 32'(rsp_valid), 32'h1);
        check("w_idle_psel2", 32'(psel), 32'h0);
        @(negedge clk);
        #1 check("w_rsp_once", 32'(rsp_valid), 32'h0);

        // Requester 1 read, three wait states; valid toggling mid-transfer is ignored
        req_valid = 2'b10; req_write = 2'b00;
        req_addr = {32'h0000_A000, 32'h0}; pready = 1'b0; prdata = 32'h0;
        #1 check("r_req_ready", 32'(req_ready), 32'h2);
        q.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0));
        @(negedge clk);
        req_valid = 2'b01;
        #1 check("r_setup_pwrite", 32'(pwrite), 32'h0);
        check("r_setup_ready_ignored", 32'(req_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                pready = 1'b1; prdata = 32'hDEAD_BEEF; req_valid = 2'b00;
            end
            #1 check($sformatf("r_access_penable_%0d", i), 32'(penable), 32'h1);
            check($sformatf("r_access_ready_ignored_%0d", i), 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        #1 check("r_done_penable", 32'(penable), 32'h0);
        check("r_rsp_pulse", 32'(rsp_valid), 32'h2);
        @(negedge clk);

        // Requester 0 write with slave error
        req_valid = 2'b01; req_write = 2'b01; pslverr = 1'b1; prdata = 32'h1234_5678;
        #1 check("e_req_ready", 32'(req_ready), 32'h1);
        q.push_back(mk(1'b0, 32'h0, 1'b1));
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        #1 check("e_rsp_slverr", 32'(rsp_slverr), 32'h1);
        pslverr = 1'b0;
        @(negedge clk);

        // Reset during ACCESS with the pointer at requester 1
        req_valid = 2'b01; req_write = 2'b00; pready = 1'b0;
        #1 check("a_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 check("a_access_penable", 32'(penable), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("a_rst_psel", 32'(psel), 32'h0);
        check("a_rst_penable", 32'(penable), 32'h0);
        check("a_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        req_valid = 2'b11;
        #1 check("a_rst_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; req_write = 2'b11; pready = 1'b1;
        req_addr = {32'h0000_1111, 32'h0000_2220};

        // Both requesters held valid: alternate 0,1,0,1, one SETUP every 3 cycles
        for (int k = 0; k < 4; k++) begin
            logic            who;
            logic [31:0]     a;
            who = (k % 2) == 1;
            a   = who ? 32'h0000_1111 : 32'h0000_2220;
            #1 check($sformatf("rr_grant_%0d", k), 32'(req_ready), who ? 32'h2 : 32'h1);
            check($sformatf("rr_idle_psel_%0d", k), 32'(psel), 32'h0);
            q.push_back(mk(who, 32'h0, 1'b0));
            @(negedge clk);
            #1 check($sformatf("rr_setup_psel_%0d", k), 32'(psel), 32'h1);
            check($sformatf("rr_setup_penable_%0d", k), 32'(penable), 32'h0);
            check($sformatf("rr_setup_paddr_%0d", k), paddr, a);
            @(negedge clk);
            #1 check($sformatf("rr_access_penable_%0d", k), 32'(penable), 32'h1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: transfer gives up after 16 ACCESS cycles
        begin
            int  n;
            bit  done;
            n = 0; done = 1'b0;
            req_valid = 2'b01; req_write = 2'b00; pready = 1'b0; prdata = 32'h5555_5555;
            q.push_back(mk(1'b0, 32'h0, 1'b1));
            @(negedge clk);
            req_valid = 2'b00;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                #1;
                if (penable) n++;
                else done = 1'b1;
            end
            check("to_access_cycles", 32'(n), 32'd16);
            check("to_psel_released", 32'(psel), 32'h0);
            repeat (2) @(negedge clk);
        end
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
